// File: rtl/div_tick_sched.sv
// div_tick_sched: divided square wave plus 1-cycle tick at ratio 2^(sel_cur+1); define DIV_TICK_GATE_EN for the tick gate input.
// Latency: all outputs registered; sel_ack follows the sampled request by one cycle.
// Backpressure: while a change is pending (busy) new requests get no ack and must be held.
module div_tick_sched #(
   parameter int WIDTH       = 9,
   parameter int DEFAULT_SEL = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       sel_req,
   input  logic [3:0] sel_in,
`ifdef DIV_TICK_GATE_EN
   input  logic       gate,
`endif
   output logic       sel_ack,
   output logic       sel_err,
   output logic [3:0] sel_cur,
   output logic       busy,
   output logic       tick,
   output logic       sq_out
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2} state_t;

   localparam logic [3:0] SEL_MAX = 4'(WIDTH - 1);
   localparam logic [3:0] SEL_RST = 4'(DEFAULT_SEL);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] tc_mask;
   logic [3:0]       sel_cur_q, sel_cur_d;
   logic [3:0]       pend_sel_q, pend_sel_d;
   logic [3:0]       req_sel;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;
   logic             req_take, req_oor, tc;

   // The ack cycle itself is excluded so a requester dropping sel_req on ack is not sampled twice.
   assign req_take = sel_req && (state_q != PEND) && !ack_q;
   assign req_oor  = (int'(sel_in) >= WIDTH);
   assign req_sel  = req_oor ? SEL_MAX : sel_in;
   assign tc_mask  = ~({WIDTH{1'b1}} << (sel_cur_q + 4'd1));
   assign tc       = ((cnt_q & tc_mask) == tc_mask);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sel_cur_d  = sel_cur_q;
      pend_sel_d = pend_sel_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      tick_d     = 1'b0;
      sq_d       = 1'b0;

      if (req_take) begin
         ack_d = 1'b1;
         err_d = req_oor;
      end

      if (!en) begin
         state_d = IDLE;
         cnt_d   = '0;
         if (state_q == PEND) sel_cur_d = pend_sel_q;
         if (req_take)        sel_cur_d = req_sel;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = RUN;
               cnt_d   = '0;
               if (req_take) sel_cur_d = req_sel;
            end
            RUN: begin
               cnt_d  = cnt_q + WIDTH'(1);
               tick_d = tc;
               sq_d   = cnt_q[sel_cur_q];
               if (req_take && (req_sel != sel_cur_q)) begin
                  pend_sel_d = req_sel;
                  state_d    = PEND;
               end
            end
            PEND: begin
               tick_d = tc;
               sq_d   = cnt_q[sel_cur_q];
               // Switch only at the old period's terminal count; its tick still goes out.
               if (tc) begin
                  sel_cur_d = pend_sel_q;
                  cnt_d     = '0;
                  state_d   = RUN;
               end else begin
                  cnt_d = cnt_q + WIDTH'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

`ifdef DIV_TICK_GATE_EN
      if (gate) tick_d = 1'b0;
`endif
      busy_d = (state_d == PEND);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sel_cur_q  <= SEL_RST;
         pend_sel_q <= SEL_RST;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         tick_q     <= 1'b0;
         sq_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_cur_q  <= sel_cur_d;
         pend_sel_q <= pend_sel_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         tick_q     <= tick_d;
         sq_q       <= sq_d;
      end
   end

   assign sel_ack = ack_q;
   assign sel_err = err_q;
   assign sel_cur = sel_cur_q;
   assign busy    = busy_q;
   assign tick    = tick_q;
   assign sq_out  = sq_q;

endmodule

// File: tb/tb_div_tick_sched.sv
// Bench for div_tick_sched: expected tick cycles and ack records are queued as stimulus is driven,
// then matched against the events the monitor captures from the DUT.
module tb_div_tick_sched;

   typedef struct {
      int         c;
      logic [3:0] s;
      logic       e;
   } ack_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       sel_req = 1'b0;
   logic [3:0] sel_in = 4'd0;
   logic       gate = 1'b0;
   logic       sel_ack, sel_err, busy, tick, sq_out;
   logic [3:0] sel_cur;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   base = 0;
   int   obs_tick[$];
   int   exp_tick[$];
   ack_t obs_ack[$];
   ack_t exp_ack[$];

   div_tick_sched #(.WIDTH(9), .DEFAULT_SEL(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .sel_req (sel_req),
      .sel_in  (sel_in),
`ifdef DIV_TICK_GATE_EN
      .gate    (gate),
`endif
      .sel_ack (sel_ack),
      .sel_err (sel_err),
      .sel_cur (sel_cur),
      .busy    (busy),
      .tick    (tick),
      .sq_out  (sq_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ack_t a;
      #1;
      cyc = cyc + 1;
      if (tick) obs_tick.push_back(cyc);
      if (sel_ack) begin
         a.c = cyc;
         a.s = sel_cur;
         a.e = sel_err;
         obs_ack.push_back(a);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_q();
      obs_tick.delete();
      exp_tick.delete();
      obs_ack.delete();
      exp_ack.delete();
   endtask

   task automatic push_ack(input int c, input logic [3:0] s, input logic e);
      ack_t a;
      a.c = c;
      a.s = s;
      a.e = e;
      exp_ack.push_back(a);
   endtask

   // Stimulus only: park in IDLE, request v, wait (bounded) for the ack, release.
   task automatic set_sel_idle(input logic [3:0] v, output bit got);
      got = 1'b0;
      en = 1'b0;
      step();
      sel_req = 1'b1;
      sel_in = v;
      for (int i = 0; i < 8; i++) begin
         step();
         if (sel_ack) begin
            got = 1'b1;
            break;
         end
      end
      sel_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      n_chk += 6;
      if (sel_cur !== 4'd8) begin n_fail++; $display("FAIL reset_sel_cur got %0d want 8", sel_cur); end
      if (sel_ack !== 1'b0) begin n_fail++; $display("FAIL reset_sel_ack got %b want 0", sel_ack); end
      if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err got %b want 0", sel_err); end
      if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      if (tick !== 1'b0)    begin n_fail++; $display("FAIL reset_tick got %b want 0", tick); end
      if (sq_out !== 1'b0)  begin n_fail++; $display("FAIL reset_sq_out got %b want 0", sq_out); end
   endtask

   task automatic test_default_div();
      int sq_bad = 0;
      int t;
      logic want;
      rst = 1'b0;
      repeat (2) step();
      clear_q();
      base = cyc;
      en = 1'b1;
      exp_tick.push_back(base + 1 + 512);
      exp_tick.push_back(base + 1 + 1024);
      for (int i = 0; i < 1030; i++) begin
         step();
         t = cyc;
         want = (t >= base + 2) ? (((t - base - 2) % 512) >= 256) : 1'b0;
         if (sq_out !== want) sq_bad++;
      end
      n_chk++;
      if (sq_bad != 0) begin n_fail++; $display("FAIL default_sq_pattern got %0d bad cycles want 0", sq_bad); end
      n_chk++;
      if (obs_tick.size() != exp_tick.size()) begin
         n_fail++; $display("FAIL default_tick_count got %0d want %0d", obs_tick.size(), exp_tick.size());
      end
      while (obs_tick.size() > 0 && exp_tick.size() > 0) begin
         int o = obs_tick.pop_front();
         int e = exp_tick.pop_front();
         n_chk++;
         if (o !== e) begin n_fail++; $display("FAIL default_tick_cycle got %0d want %0d", o, e); end
      end
   endtask

   task automatic test_idle_sel();
      bit got;
      int r;
      en = 1'b0;
      step();
      clear_q();
      r = cyc;
      sel_req = 1'b1;
      sel_in = 4'd0;
      push_ack(r + 1, 4'd0, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (sel_ack) begin got = 1'b1; break; end
      end
      sel_req = 1'b0;
      n_chk++;
      if (!got) begin n_fail++; $display("FAIL idle_ack_timeout got none want ack"); end
      base = cyc;
      en = 1'b1;
      for (int k = 1; k <= 4; k++) exp_tick.push_back(base + 1 + 2 * k);
      repeat (10) step();
      n_chk++;
      if (obs_ack.size() != exp_ack.size()) begin
         n_fail++; $display("FAIL idle_ack_count got %0d want %0d", obs_ack.size(), exp_ack.size());
      end
      while (obs_ack.size() > 0 && exp_ack.size() > 0) begin
         ack_t o = obs_ack.pop_front();
         ack_t e = exp_ack.pop_front();
         n_chk++;
         if (o.c !== e.c || o.s !== e.s || o.e !== e.e) begin
            n_fail++; $display("FAIL idle_ack got c=%0d sel=%0d err=%b want c=%0d sel=%0d err=%b", o.c, o.s, o.e, e.c, e.s, e.e);
         end
      end
      n_chk++;
      if (obs_tick.size() != exp_tick.size()) begin
         n_fail++; $display("FAIL idle_tick_count got %0d want %0d", obs_tick.size(), exp_tick.size());
      end
      while (obs_tick.size() > 0 && exp_tick.size() > 0) begin
         int o = obs_tick.pop_front();
         int e = exp_tick.pop_front();
         n_chk++;
         if (o !== e) begin n_fail++; $display("FAIL idle_tick_cycle got %0d want %0d", o, e); end
      end
   endtask

   task automatic test_pend();
      bit got;
      int t;
      set_sel_idle(4'd3, got);
      n_chk++;
      if (!got || sel_cur !== 4'd3) begin n_fail++; $display("FAIL pend_setup got sel=%0d ack=%b want sel=3 ack=1", sel_cur, got); end
      clear_q();
      base = cyc;
      en = 1'b1;
      push_ack(base + 7, 4'd3, 1'b0);
      push_ack(base + 18, 4'd1, 1'b0);
      exp_tick.push_back(base + 17);
      exp_tick.push_back(base + 21);
      exp_tick.push_back(base + 29);
      exp_tick.push_back(base + 37);
      for (int i = 0; i < 40; i++) begin
         step();
         t = cyc - base;
         if (sel_ack) sel_req = 1'b0;
         if (t == 6)  begin sel_req = 1'b1; sel_in = 4'd1; end
         if (t == 9)  begin sel_req = 1'b1; sel_in = 4'd2; end
         if (t == 10) begin
            n_chk++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL pend_busy_mid got %b want 1", busy); end
         end
         if (t == 17) begin
            n_chk += 2;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL pend_busy_exit got %b want 0", busy); end
            if (sel_cur !== 4'd1) begin n_fail++; $display("FAIL pend_sel_apply1 got %0d want 1", sel_cur); end
         end
         if (t == 21) begin
            n_chk++;
            if (sel_cur !== 4'd2) begin n_fail++; $display("FAIL pend_sel_apply2 got %0d want 2", sel_cur); end
         end
      end
      sel_req = 1'b0;
      n_chk++;
      if (obs_ack.size() != exp_ack.size()) begin
         n_fail++; $display("FAIL pend_ack_count got %0d want %0d", obs_ack.size(), exp_ack.size());
      end
      while (obs_ack.size() > 0 && exp_ack.size() > 0) begin
         ack_t o = obs_ack.pop_front();
         ack_t e = exp_ack.pop_front();
         n_chk++;
         if (o.c !== e.c || o.s !== e.s || o.e !== e.e) begin
            n_fail++; $display("FAIL pend_ack got c=%0d sel=%0d err=%b want c=%0d sel=%0d err=%b", o.c - base, o.s, o.e, e.c - base, e.s, e.e);
         end
      end
      n_chk++;
      if (obs_tick.size() != exp_tick.size()) begin
         n_fail++; $display("FAIL pend_tick_count got %0d want %0d", obs_tick.size(), exp_tick.size());
      end
      while (obs_tick.size() > 0 && exp_tick.size() > 0) begin
         int o = obs_tick.pop_front();
         int e = exp_tick.pop_front();
         n_chk++;
         if (o !== e) begin n_fail++; $display("FAIL pend_tick_cycle got %0d want %0d", o - base, e - base); end
      end
   endtask

   // Continues from test_pend: sel 2 running, terminal count due at base+44.
   task automatic test_en_drop();
      int e0;
      while (cyc < base + 44) step();
      en = 1'b0;
      step();
      n_chk += 3;
      if (tick !== 1'b0)   begin n_fail++; $display("FAIL endrop_tick got %b want 0", tick); end
      if (sq_out !== 1'b0) begin n_fail++; $display("FAIL endrop_sq_out got %b want 0", sq_out); end
      if (busy !== 1'b0)   begin n_fail++; $display("FAIL endrop_busy got %b want 0", busy); end
      clear_q();
      e0 = cyc;
      en = 1'b1;
      exp_tick.push_back(e0 + 9);
      repeat (12) step();
      n_chk++;
      if (sel_cur !== 4'd2) begin n_fail++; $display("FAIL endrop_sel_cur got %0d want 2", sel_cur); end
      n_chk++;
      if (obs_tick.size() != exp_tick.size()) begin
         n_fail++; $display("FAIL endrop_tick_count got %0d want %0d", obs_tick.size(), exp_tick.size());
      end
      while (obs_tick.size() > 0 && exp_tick.size() > 0) begin
         int o = obs_tick.pop_front();
         int e = exp_tick.pop_front();
         n_chk++;
         if (o !== e) begin n_fail++; $display("FAIL endrop_tick_cycle got %0d want %0d", o - e0, e - e0); end
      end
   endtask

   task automatic test_same_sel();
      bit got;
      int t;
      set_sel_idle(4'd3, got);
      clear_q();
      base = cyc;
      en = 1'b1;
      push_ack(base + 7, 4'd3, 1'b0);
      exp_tick.push_back(base + 17);
      exp_tick.push_back(base + 33);
      for (int i = 0; i < 34; i++) begin
         step();
         t = cyc - base;
         if (sel_ack) sel_req = 1'b0;
         if (t == 6) begin sel_req = 1'b1; sel_in = 4'd3; end
         if (t == 8) begin
            n_chk++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL same_busy got %b want 0", busy); end
         end
      end
      sel_req = 1'b0;
      n_chk++;
      if (obs_ack.size() != exp_ack.size()) begin
         n_fail++; $display("FAIL same_ack_count got %0d want %0d", obs_ack.size(), exp_ack.size());
      end
      while (obs_ack.size() > 0 && exp_ack.size() > 0) begin
         ack_t o = obs_ack.pop_front();
         ack_t e = exp_ack.pop_front();
         n_chk++;
         if (o.c !== e.c || o.s !== e.s || o.e !== e.e) begin
            n_fail++; $display("FAIL same_ack got c=%0d sel=%0d err=%b want c=%0d sel=%0d err=%b", o.c - base, o.s, o.e, e.c - base, e.s, e.e);
         end
      end
      n_chk++;
      if (obs_tick.size() != exp_tick.size()) begin
         n_fail++; $display("FAIL same_tick_count got %0d want %0d", obs_tick.size(), exp_tick.size());
      end
      while (obs_tick.size() > 0 && exp_tick.size() > 0) begin
         int o = obs_tick.pop_front();
         int e = exp_tick.pop_front();
         n_chk++;
         if (o !== e) begin n_fail++; $display("FAIL same_tick_cycle got %0d want %0d", o - base, e - base); end
      end
   endtask

   task automatic test_clamp();
      logic [3:0] req_v [4] = '{4'd12, 4'd4, 4'd9, 4'd8};
      logic [3:0] want_s[4] = '{4'd8, 4'd4, 4'd8, 4'd8};
      logic       want_e[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      bit got;
      en = 1'b0;
      step();
      for (int k = 0; k < 4; k++) begin
         clear_q();
         push_ack(cyc + 1, want_s[k], want_e[k]);
         sel_req = 1'b1;
         sel_in = req_v[k];
         got = 1'b0;
         for (int i = 0; i < 8; i++) begin
            step();
            if (sel_ack) begin got = 1'b1; break; end
         end
         sel_req = 1'b0;
         step();
         n_chk++;
         if (sel_ack !== 1'b0 || sel_err !== 1'b0) begin
            n_fail++; $display("FAIL clamp_pulse_width in=%0d got ack=%b err=%b want 0 0", req_v[k], sel_ack, sel_err);
         end
         n_chk++;
         if (obs_ack.size() != 1) begin n_fail++; $display("FAIL clamp_ack_count in=%0d got %0d want 1", req_v[k], obs_ack.size()); end
         if (obs_ack.size() > 0) begin
            ack_t o = obs_ack.pop_front();
            ack_t e = exp_ack.pop_front();
            n_chk++;
            if (o.c !== e.c || o.s !== e.s || o.e !== e.e) begin
               n_fail++; $display("FAIL clamp_ack in=%0d got c=%0d sel=%0d err=%b want c=%0d sel=%0d err=%b", req_v[k], o.c, o.s, o.e, e.c, e.s, e.e);
            end
         end
      end
   endtask

   task automatic test_rst_busy();
      bit got;
      int t;
      set_sel_idle(4'd3, got);
      clear_q();
      base = cyc;
      en = 1'b1;
      push_ack(base + 4, 4'd3, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step();
         t = cyc - base;
         if (sel_ack) sel_req = 1'b0;
         if (t == 3) begin sel_req = 1'b1; sel_in = 4'd2; end
         if (t == 5) begin sel_req = 1'b1; sel_in = 4'd5; end
      end
      n_chk++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_before got %b want 1", busy); end
      rst = 1'b1;
      #1;
      n_chk += 3;
      if (sel_cur !== 4'd8) begin n_fail++; $display("FAIL rst_busy_sel_cur got %0d want 8", sel_cur); end
      if (busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy_busy got %b want 0", busy); end
      if (sel_ack !== 1'b0) begin n_fail++; $display("FAIL rst_busy_ack got %b want 0", sel_ack); end
      repeat (3) step();
      sel_req = 1'b0;
      en = 1'b0;
      rst = 1'b0;
      step();
      n_chk++;
      if (obs_ack.size() != exp_ack.size()) begin
         n_fail++; $display("FAIL rst_busy_ack_count got %0d want %0d", obs_ack.size(), exp_ack.size());
      end
      while (obs_ack.size() > 0 && exp_ack.size() > 0) begin
         ack_t o = obs_ack.pop_front();
         ack_t e = exp_ack.pop_front();
         n_chk++;
         if (o.c !== e.c || o.s !== e.s || o.e !== e.e) begin
            n_fail++; $display("FAIL rst_busy_ack got c=%0d sel=%0d err=%b want c=%0d sel=%0d err=%b", o.c - base, o.s, o.e, e.c - base, e.s, e.e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_default_div();
      test_idle_sel();
      test_pend();
      test_en_drop();
      test_same_sel();
      test_clamp();
      test_rst_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
